cbus_arbiter: RTL and testbench
===============================

// Module: cbus_arbiter
// PURPOSE
//  Sits directly downstream of the pipelined core. Merges the core's instruction bus (ibus) and
//  data bus (dbus) onto one single-beat memory bus (cbus). Arbitrates between requesters,
//  latches the winning request and returns the addr_ok/data_ok handshake to the winner.
//  Keeps a per-transaction cycle counter for hang detection.
// PARAMETERS
//  RR_ENABLE      0   1: round-robin on conflict; 0: dbus always wins
//  TIMEOUT_CYCLES 1024  busy cycles before err sets; 0 disables the watchdog
// PORTS
//  clk          in   1   core clock (the single clock)
//  reset        in   1   reset; one clock; reset is asynchronous and active-low
//  i_valid      in   1   ibus request valid; held until i_addr_ok
//  i_addr       in   64  fetch address (4-byte aligned)
//  i_addr_ok    out  1   ibus request accepted
//  i_data_ok    out  1   ibus data valid
//  i_data       out  32  fetched instruction word
//  d_valid      in   1   dbus request valid; held until d_addr_ok
//  d_addr       in   64  load/store address
//  d_size       in   3   log2 bytes (0..3)
//  d_strobe     in   8   byte write enables; 0 = load
//  d_wdata      in   64  store data
//  d_addr_ok    out  1   dbus request accepted
//  d_data_ok    out  1   dbus data valid
//  d_data       out  64  load data
//  c_valid      out  1   cbus request valid
//  c_is_write   out  1   1 = write
//  c_size       out  3   log2 bytes
//  c_addr       out  64  request address
//  c_strobe     out  8   byte enables
//  c_wdata      out  64  write data
//  c_len        out  4   beats-1; constant 0
//  c_ready      in   1   cbus beat accepted
//  c_last       in   1   final beat
//  c_rdata      in   64  read data
//  err          out  1   sticky watchdog flag
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE; request buffer, busy_cnt, err = 0; last_grant = I.
//    All outputs are 0 immediately; no ok pulse can occur while in reset.
//  - FSM states: IDLE, BUSY_I, BUSY_D.
//    IDLE: If neither valid is set, stay in IDLE.
//      If one is set, grant it.
//      If both are set: RR_ENABLE=0 -> D; RR_ENABLE=1 -> the one != last_grant.
//      On grant: latch the request into the buffer, set last_grant, go to BUSY_x.
//    BUSY_x: c_valid=1 from the buffer. Requester inputs are ignored; changes do not affect cbus.
//      On (c_ready && c_last): pulse x_addr_ok = x_data_ok = 1 for that cycle (combinational).
//      Return to IDLE next cycle. c_ready without c_last: stay in BUSY.
//  - Latency: valid seen in cycle t -> c_valid at t+1. Completion cycle k -> ok pulse in cycle k.
//    Back-to-back grants are separated by >=1 IDLE cycle.
//  - ibus buffer fields: is_write=0, size=3'b010, strobe=0, wdata=0, addr=i_addr.
//  - dbus buffer fields: is_write=|d_strobe, size/strobe/wdata/addr passed through as given.
//  - Read data: i_data = addr[2] ? c_rdata[63:32] : c_rdata[31:0]. d_data = c_rdata.
//    Both are valid only in the data_ok cycle and are 0 otherwise.
//  - ok outputs of the non-granted requester are always 0. Never assert both ok sets in one cycle.
//  - Watchdog: busy_cnt clears on entry to BUSY and increments each BUSY cycle (saturating).
//    When busy_cnt reaches TIMEOUT_CYCLES (!=0), err is set; it clears only on reset.
//    The FSM keeps waiting (no abort).
//  - Reset mid-BUSY: transaction is dropped, c_valid falls asynchronously.
//    The core re-issues after reset.
// TESTING
//  1 reset=0 with i_valid=d_valid=1 -> all outputs 0. Release -> grant begins next edge.
//  2 i_valid, i_addr=0x8000_0004. c_ready&c_last 3 cycles after c_valid, c_rdata=0xDEADBEEF_12345678
//    -> c_valid at t+1, c_size=2, c_addr=0x8000_0004; 1-cycle i_addr_ok=i_data_ok=1, i_data=0xDEADBEEF.
//  3 RR_ENABLE=0, both valid. d_addr=0x8000_1000, d_strobe=0xFF, d_wdata=0x1122334455667788
//    -> write issued first, c_is_write=1; after d ok + 1 IDLE cycle, ibus read issued.
//  4 RR_ENABLE=1, both valid for two rounds -> grant order D, I.
//    Third conflict after D-only request -> I.
//  5 BUSY_D with d_addr changed to 0x8000_2000 mid-transaction -> c_addr stays 0x8000_1000 until completion.
//  6 TIMEOUT_CYCLES=8, c_ready=0 -> err=1 on 8th BUSY cycle, stays 1 after completion.
//    reset=0 mid-BUSY -> c_valid=0 at once, err=0, no ok pulse.

Source files
------------

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: merges the core's ibus and dbus onto one single-beat memory bus (cbus).
// One request is buffered and replayed on cbus; a sticky watchdog flags hung transactions.
module cbus_arbiter #(
   parameter int RR_ENABLE      = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_valid,
   input  logic [63:0] i_addr,
   output logic        i_addr_ok,
   output logic        i_data_ok,
   output logic [31:0] i_data,
   input  logic        d_valid,
   input  logic [63:0] d_addr,
   input  logic [2:0]  d_size,
   input  logic [7:0]  d_strobe,
   input  logic [63:0] d_wdata,
   output logic        d_addr_ok,
   output logic        d_data_ok,
   output logic [63:0] d_data,
   output logic        c_valid,
   output logic        c_is_write,
   output logic [2:0]  c_size,
   output logic [63:0] c_addr,
   output logic [7:0]  c_strobe,
   output logic [63:0] c_wdata,
   output logic [3:0]  c_len,
   input  logic        c_ready,
   input  logic        c_last,
   input  logic [63:0] c_rdata,
   output logic        err
);

   localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   typedef struct packed {
      logic        is_write;
      logic [2:0]  size;
      logic [63:0] addr;
      logic [7:0]  strobe;
      logic [63:0] wdata;
   } req_t;

   state_t           state;
   req_t             req_q;
   req_t             i_req;
   req_t             d_req;
   logic             last_d;
   logic [CNT_W-1:0] busy_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             err_q;
   logic             busy;
   logic             pick_d;
   logic             i_ok;
   logic             d_ok;

   assign i_req = '{is_write: 1'b0, size: 3'b010, addr: i_addr, strobe: 8'h00, wdata: 64'h0};
   assign d_req = '{is_write: |d_strobe, size: d_size, addr: d_addr, strobe: d_strobe,
                    wdata: d_wdata};

   // On conflict: fixed priority favours dbus, round-robin favours whoever did not win last.
   always_comb begin
      pick_d = d_valid;
      if (i_valid && d_valid) begin
         pick_d = (RR_ENABLE == 0) ? 1'b1 : !last_d;
      end
   end

   assign busy    = (state != IDLE);
   assign cnt_inc = (busy_cnt == '1) ? busy_cnt : busy_cnt + 1'b1;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         req_q    <= '0;
         last_d   <= 1'b0;
         busy_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid || d_valid) begin
                  req_q    <= pick_d ? d_req : i_req;
                  last_d   <= pick_d;
                  busy_cnt <= '0;
                  state    <= pick_d ? BUSY_D : BUSY_I;
               end
            end
            default: begin
               // err rises on the edge that closes the TIMEOUT_CYCLES-th busy cycle.
               busy_cnt <= cnt_inc;
               if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_V)) begin
                  err_q <= 1'b1;
               end
               if (c_ready && c_last) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign i_ok = (state == BUSY_I) && c_ready && c_last;
   assign d_ok = (state == BUSY_D) && c_ready && c_last;

   assign i_addr_ok = i_ok;
   assign i_data_ok = i_ok;
   assign i_data    = i_ok ? (req_q.addr[2] ? c_rdata[63:32] : c_rdata[31:0]) : 32'h0;
   assign d_addr_ok = d_ok;
   assign d_data_ok = d_ok;
   assign d_data    = d_ok ? c_rdata : 64'h0;

   assign c_valid    = busy;
   assign c_is_write = busy & req_q.is_write;
   assign c_size     = busy ? req_q.size   : 3'h0;
   assign c_addr     = busy ? req_q.addr   : 64'h0;
   assign c_strobe   = busy ? req_q.strobe : 8'h0;
   assign c_wdata    = busy ? req_q.wdata  : 64'h0;
   assign c_len      = 4'h0;
   assign err        = err_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: two instances (fixed priority with an 8-cycle watchdog, and
// round-robin with the default watchdog) share stimulus; directed scenarios plus a random run.
module tb_cbus_arbiter;

   logic        clk;
   logic        reset;
   logic        i_valid;
   logic [63:0] i_addr;
   logic        d_valid;
   logic [63:0] d_addr;
   logic [2:0]  d_size;
   logic [7:0]  d_strobe;
   logic [63:0] d_wdata;
   logic        c_ready;
   logic        c_last;
   logic [63:0] c_rdata;

   logic        i_addr_ok  [2];
   logic        i_data_ok  [2];
   logic [31:0] i_data     [2];
   logic        d_addr_ok  [2];
   logic        d_data_ok  [2];
   logic [63:0] d_data     [2];
   logic        c_valid    [2];
   logic        c_is_write [2];
   logic [2:0]  c_size     [2];
   logic [63:0] c_addr     [2];
   logic [7:0]  c_strobe   [2];
   logic [63:0] c_wdata    [2];
   logic [3:0]  c_len      [2];
   logic        err        [2];

   int n_pass  = 0;
   int n_total = 0;

   // Instance 0: dbus priority, watchdog 8. Instance 1: round-robin, watchdog 1024.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      cbus_arbiter #(
         .RR_ENABLE      (g),
         .TIMEOUT_CYCLES ((g == 0) ? 8 : 1024)
      ) dut (
         .clk        (clk),
         .reset      (reset),
         .i_valid    (i_valid),
         .i_addr     (i_addr),
         .i_addr_ok  (i_addr_ok[g]),
         .i_data_ok  (i_data_ok[g]),
         .i_data     (i_data[g]),
         .d_valid    (d_valid),
         .d_addr     (d_addr),
         .d_size     (d_size),
         .d_strobe   (d_strobe),
         .d_wdata    (d_wdata),
         .d_addr_ok  (d_addr_ok[g]),
         .d_data_ok  (d_data_ok[g]),
         .d_data     (d_data[g]),
         .c_valid    (c_valid[g]),
         .c_is_write (c_is_write[g]),
         .c_size     (c_size[g]),
         .c_addr     (c_addr[g]),
         .c_strobe   (c_strobe[g]),
         .c_wdata    (c_wdata[g]),
         .c_len      (c_len[g]),
         .c_ready    (c_ready),
         .c_last     (c_last),
         .c_rdata    (c_rdata),
         .err        (err[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model (transaction level) ----------------
   int          m_owner [2];   // 0 none, 1 ibus, 2 dbus
   int          m_last  [2];   // last winner, 1 ibus, 2 dbus
   int          m_wait  [2];   // busy cycles completed
   bit          m_err   [2];
   bit          m_wr    [2];
   logic [2:0]  m_size  [2];
   logic [63:0] m_addr  [2];
   logic [7:0]  m_strb  [2];
   logic [63:0] m_wdat  [2];
   int          m_to    [2] = '{8, 1024};

   task automatic model_clear(input int k);
      m_owner[k] = 0;
      m_last[k]  = 1;
      m_wait[k]  = 0;
      m_err[k]   = 1'b0;
   endtask

   task automatic model_step(input int k, input bit done);
      int w;
      if (m_owner[k] == 0) begin
         if (i_valid || d_valid) begin
            if (i_valid && d_valid) w = (k == 1) ? ((m_last[k] == 2) ? 1 : 2) : 2;
            else                    w = d_valid ? 2 : 1;
            m_owner[k] = w;
            m_last[k]  = w;
            m_wait[k]  = 0;
            m_wr[k]    = (w == 2) && (d_strobe != 8'h0);
            m_size[k]  = (w == 2) ? d_size   : 3'd2;
            m_addr[k]  = (w == 2) ? d_addr   : i_addr;
            m_strb[k]  = (w == 2) ? d_strobe : 8'h0;
            m_wdat[k]  = (w == 2) ? d_wdata  : 64'h0;
         end
      end else begin
         m_wait[k] = m_wait[k] + 1;
         if (m_to[k] != 0 && m_wait[k] == m_to[k]) m_err[k] = 1'b1;
         if (done) m_owner[k] = 0;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      i_valid = 1'b0;
      d_valid = 1'b0;
      c_ready = 1'b0;
      c_last  = 1'b0;
      tick();
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic quiesce();
      i_valid = 1'b0;
      d_valid = 1'b0;
      c_ready = 1'b1;
      c_last  = 1'b1;
      tick();
      tick();
      c_ready = 1'b0;
      c_last  = 1'b0;
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      i_valid = 1'b1; i_addr = 64'h8000_0004;
      d_valid = 1'b1; d_addr = 64'h8000_1000; d_size = 3'd3; d_strobe = 8'h00; d_wdata = 64'h0;
      c_ready = 1'b1; c_last = 1'b1; c_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            n_total++; if (c_valid[k] !== 1'b0) $display("FAIL rst_c_valid[%0d]: got %b want 0", k, c_valid[k]); else n_pass++;
            n_total++; if (i_addr_ok[k] !== 1'b0 || i_data_ok[k] !== 1'b0) $display("FAIL rst_i_ok[%0d]: got %b%b want 00", k, i_addr_ok[k], i_data_ok[k]); else n_pass++;
            n_total++; if (d_addr_ok[k] !== 1'b0 || d_data_ok[k] !== 1'b0) $display("FAIL rst_d_ok[%0d]: got %b%b want 00", k, d_addr_ok[k], d_data_ok[k]); else n_pass++;
            n_total++; if (i_data[k] !== 32'h0 || d_data[k] !== 64'h0) $display("FAIL rst_data[%0d]: got %h %h want 0", k, i_data[k], d_data[k]); else n_pass++;
            n_total++; if (c_addr[k] !== 64'h0 || c_is_write[k] !== 1'b0 || c_strobe[k] !== 8'h0) $display("FAIL rst_cbus[%0d]: got %h %b %h want 0", k, c_addr[k], c_is_write[k], c_strobe[k]); else n_pass++;
            n_total++; if (err[k] !== 1'b0) $display("FAIL rst_err[%0d]: got %b want 0", k, err[k]); else n_pass++;
         end
      end
      c_ready = 1'b0; c_last = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_total++; if (c_valid[k] !== 1'b0) $display("FAIL rel_c_valid[%0d]: got %b want 0", k, c_valid[k]); else n_pass++;
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         n_total++; if (c_valid[k] !== 1'b1 || c_addr[k] !== 64'h8000_1000) $display("FAIL rel_grant[%0d]: got %b %h want 1 80001000", k, c_valid[k], c_addr[k]); else n_pass++;
      end
      quiesce();
   endtask

   task automatic test_ibus_read();
      i_valid = 1'b1; i_addr = 64'h8000_0004;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_total++; if (c_valid[k] !== 1'b0) $display("FAIL ird_t0[%0d]: got %b want 0", k, c_valid[k]); else n_pass++;
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         n_total++; if (c_valid[k] !== 1'b1 || c_addr[k] !== 64'h8000_0004) $display("FAIL ird_req[%0d]: got %b %h want 1 80000004", k, c_valid[k], c_addr[k]); else n_pass++;
         n_total++; if (c_size[k] !== 3'd2 || c_is_write[k] !== 1'b0 || c_strobe[k] !== 8'h0 || c_len[k] !== 4'h0) $display("FAIL ird_fields[%0d]: got %0d %b %h %0d want 2 0 00 0", k, c_size[k], c_is_write[k], c_strobe[k], c_len[k]); else n_pass++;
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            n_total++; if (i_addr_ok[k] !== 1'b0 || c_valid[k] !== 1'b1) $display("FAIL ird_wait[%0d]: got ok=%b valid=%b want 0 1", k, i_addr_ok[k], c_valid[k]); else n_pass++;
         end
      end
      tick();
      c_ready = 1'b1; c_last = 1'b1; c_rdata = 64'hDEADBEEF_12345678;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_total++; if (i_addr_ok[k] !== 1'b1 || i_data_ok[k] !== 1'b1) $display("FAIL ird_ok[%0d]: got %b%b want 11", k, i_addr_ok[k], i_data_ok[k]); else n_pass++;
         n_total++; if (i_data[k] !== 32'hDEADBEEF) $display("FAIL ird_data[%0d]: got %h want deadbeef", k, i_data[k]); else n_pass++;
         n_total++; if (d_addr_ok[k] !== 1'b0 || d_data[k] !== 64'h0) $display("FAIL ird_dquiet[%0d]: got %b %h want 0 0", k, d_addr_ok[k], d_data[k]); else n_pass++;
      end
      tick();
      i_valid = 1'b0; c_ready = 1'b0; c_last = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_total++; if (c_valid[k] !== 1'b0 || i_data_ok[k] !== 1'b0 || i_data[k] !== 32'h0) $display("FAIL ird_after[%0d]: got %b %b %h want 0 0 0", k, c_valid[k], i_data_ok[k], i_data[k]); else n_pass++;
      end
   endtask

   task automatic test_priority();
      i_valid = 1'b1; i_addr = 64'h8000_0008;
      d_valid = 1'b1; d_addr = 64'h8000_1000; d_size = 3'd3; d_strobe = 8'hFF;
      d_wdata = 64'h1122334455667788;
      tick();
      n_total++; if (c_valid[0] !== 1'b1 || c_is_write[0] !== 1'b1 || c_addr[0] !== 64'h8000_1000) $display("FAIL pri_write: got %b %b %h want 1 1 80001000", c_valid[0], c_is_write[0], c_addr[0]); else n_pass++;
      n_total++; if (c_wdata[0] !== 64'h1122334455667788 || c_strobe[0] !== 8'hFF || c_size[0] !== 3'd3) $display("FAIL pri_fields: got %h %h %0d want 1122334455667788 ff 3", c_wdata[0], c_strobe[0], c_size[0]); else n_pass++;
      c_ready = 1'b1; c_last = 1'b1; c_rdata = 64'h0123_4567_89AB_CDEF;
      #1;
      n_total++; if (d_addr_ok[0] !== 1'b1 || d_data_ok[0] !== 1'b1 || d_data[0] !== 64'h0123_4567_89AB_CDEF) $display("FAIL pri_dok: got %b %b %h want 1 1 0123456789abcdef", d_addr_ok[0], d_data_ok[0], d_data[0]); else n_pass++;
      n_total++; if (i_addr_ok[0] !== 1'b0 || i_data_ok[0] !== 1'b0) $display("FAIL pri_iquiet: got %b%b want 00", i_addr_ok[0], i_data_ok[0]); else n_pass++;
      tick();
      d_valid = 1'b0; c_ready = 1'b0; c_last = 1'b0;
      #1;
      n_total++; if (c_valid[0] !== 1'b0) $display("FAIL pri_gap: got %b want 0", c_valid[0]); else n_pass++;
      tick();
      n_total++; if (c_valid[0] !== 1'b1 || c_addr[0] !== 64'h8000_0008 || c_is_write[0] !== 1'b0 || c_size[0] !== 3'd2) $display("FAIL pri_iread: got %b %h %b %0d want 1 80000008 0 2", c_valid[0], c_addr[0], c_is_write[0], c_size[0]); else n_pass++;
      c_ready = 1'b1; c_last = 1'b1; c_rdata = 64'hAAAAAAAA_55555555;
      #1;
      n_total++; if (i_data[0] !== 32'h55555555 || d_addr_ok[0] !== 1'b0) $display("FAIL pri_idata: got %h %b want 55555555 0", i_data[0], d_addr_ok[0]); else n_pass++;
      quiesce();
   endtask

   task automatic test_rr();
      bit exp_d;
      do_reset();
      i_valid = 1'b1; i_addr = 64'h8000_0010;
      d_valid = 1'b1; d_addr = 64'h8000_3000; d_size = 3'd2; d_strobe = 8'h00;
      for (int r = 0; r < 2; r++) begin
         exp_d = (r == 0);
         tick();
         n_total++; if (c_addr[1] !== (exp_d ? d_addr : i_addr)) $display("FAIL rr_round%0d: got %h want %h", r, c_addr[1], exp_d ? d_addr : i_addr); else n_pass++;
         c_ready = 1'b1; c_last = 1'b1;
         #1;
         n_total++; if (d_addr_ok[1] !== exp_d || i_addr_ok[1] !== !exp_d) $display("FAIL rr_ok%0d: got d=%b i=%b want d=%b", r, d_addr_ok[1], i_addr_ok[1], exp_d); else n_pass++;
         tick();
         c_ready = 1'b0; c_last = 1'b0;
         #1;
         n_total++; if (c_valid[1] !== 1'b0) $display("FAIL rr_gap%0d: got %b want 0", r, c_valid[1]); else n_pass++;
      end
      i_valid = 1'b0;
      tick();
      n_total++; if (c_addr[1] !== d_addr) $display("FAIL rr_donly: got %h want %h", c_addr[1], d_addr); else n_pass++;
      c_ready = 1'b1; c_last = 1'b1;
      #1;
      n_total++; if (d_addr_ok[1] !== 1'b1) $display("FAIL rr_donly_ok: got %b want 1", d_addr_ok[1]); else n_pass++;
      tick();
      c_ready = 1'b0; c_last = 1'b0; i_valid = 1'b1;
      tick();
      n_total++; if (c_addr[1] !== i_addr || c_is_write[1] !== 1'b0) $display("FAIL rr_third: got %h %b want %h 0", c_addr[1], c_is_write[1], i_addr); else n_pass++;
      quiesce();
   endtask

   task automatic test_hold();
      d_valid = 1'b1; d_addr = 64'h8000_1000; d_size = 3'd2; d_strobe = 8'h0F;
      d_wdata = 64'hCAFE_F00D_0000_1111;
      tick();
      n_total++; if (c_addr[0] !== 64'h8000_1000) $display("FAIL hold_start: got %h want 80001000", c_addr[0]); else n_pass++;
      d_addr = 64'h8000_2000; d_strobe = 8'hF0; d_wdata = 64'h0; d_size = 3'd0; i_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_total++; if (c_addr[0] !== 64'h8000_1000 || c_strobe[0] !== 8'h0F || c_wdata[0] !== 64'hCAFE_F00D_0000_1111 || c_size[0] !== 3'd2) $display("FAIL hold_c%0d: got %h %h %h %0d want 80001000 0f cafef00d00001111 2", c, c_addr[0], c_strobe[0], c_wdata[0], c_size[0]); else n_pass++;
      end
      c_ready = 1'b1; c_last = 1'b1;
      #1;
      n_total++; if (d_addr_ok[0] !== 1'b1 || c_addr[0] !== 64'h8000_1000) $display("FAIL hold_done: got %b %h want 1 80001000", d_addr_ok[0], c_addr[0]); else n_pass++;
      quiesce();
   endtask

   task automatic test_watchdog();
      do_reset();
      d_valid = 1'b1; d_addr = 64'h8000_4000; d_size = 3'd3; d_strobe = 8'h00;
      tick();
      for (int c = 1; c <= 8; c++) begin
         n_total++; if (err[0] !== 1'b0 || c_valid[0] !== 1'b1) $display("FAIL wd_early%0d: got err=%b valid=%b want 0 1", c, err[0], c_valid[0]); else n_pass++;
         tick();
      end
      n_total++; if (err[0] !== 1'b1) $display("FAIL wd_set: got %b want 1", err[0]); else n_pass++;
      n_total++; if (err[1] !== 1'b0) $display("FAIL wd_long: got %b want 0", err[1]); else n_pass++;
      d_valid = 1'b0; c_ready = 1'b1; c_last = 1'b1;
      #1;
      n_total++; if (d_addr_ok[0] !== 1'b1) $display("FAIL wd_done: got %b want 1", d_addr_ok[0]); else n_pass++;
      tick();
      c_ready = 1'b0; c_last = 1'b0;
      #1;
      n_total++; if (err[0] !== 1'b1 || c_valid[0] !== 1'b0) $display("FAIL wd_sticky: got err=%b valid=%b want 1 0", err[0], c_valid[0]); else n_pass++;
      d_valid = 1'b1;
      repeat (3) tick();
      n_total++; if (c_valid[0] !== 1'b1) $display("FAIL wd_busy2: got %b want 1", c_valid[0]); else n_pass++;
      d_valid = 1'b0; c_ready = 1'b1; c_last = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      n_total++; if (c_valid[0] !== 1'b0 || err[0] !== 1'b0) $display("FAIL wd_rst: got valid=%b err=%b want 0 0", c_valid[0], err[0]); else n_pass++;
      n_total++; if (d_addr_ok[0] !== 1'b0 || d_data_ok[0] !== 1'b0) $display("FAIL wd_rst_ok: got %b%b want 00", d_addr_ok[0], d_data_ok[0]); else n_pass++;
      c_ready = 1'b0; c_last = 1'b0;
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
      n_total++; if (c_valid[0] !== 1'b0) $display("FAIL wd_dropped: got %b want 0", c_valid[0]); else n_pass++;
   endtask

   task automatic test_random();
      bit   rst_now;
      bit   busy;
      bit   done;
      bit   exp_iok;
      bit   exp_dok;
      logic [31:0] exp_idata;
      do_reset();
      for (int k = 0; k < 2; k++) model_clear(k);
      for (int it = 0; it < 600; it++) begin
         rst_now  = (it == 300);
         reset    = !rst_now;
         i_valid  = ($urandom_range(0, 9) < 6);
         i_addr   = {$urandom(), $urandom()} & 64'hFFFF_FFFF_FFFF_FFFC;
         d_valid  = ($urandom_range(0, 9) < 6);
         d_addr   = {$urandom(), $urandom()};
         d_size   = 3'($urandom_range(0, 3));
         d_strobe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom());
         d_wdata  = {$urandom(), $urandom()};
         c_ready  = ($urandom_range(0, 3) != 0);
         c_last   = ($urandom_range(0, 2) != 0);
         c_rdata  = {$urandom(), $urandom()};
         #2;
         for (int k = 0; k < 2; k++) begin
            if (rst_now) model_clear(k);
            busy      = (m_owner[k] != 0);
            done      = busy && c_ready && c_last;
            exp_iok   = done && (m_owner[k] == 1);
            exp_dok   = done && (m_owner[k] == 2);
            exp_idata = exp_iok ? (m_addr[k][2] ? c_rdata[63:32] : c_rdata[31:0]) : 32'h0;
            n_total++; if (c_valid[k] !== busy) $display("FAIL rnd_valid[%0d] it=%0d: got %b want %b", k, it, c_valid[k], busy); else n_pass++;
            if (busy) begin
               n_total++; if (c_addr[k] !== m_addr[k] || c_is_write[k] !== m_wr[k] || c_size[k] !== m_size[k] || c_strobe[k] !== m_strb[k] || c_wdata[k] !== m_wdat[k]) $display("FAIL rnd_req[%0d] it=%0d: got %h %b %0d %h %h want %h %b %0d %h %h", k, it, c_addr[k], c_is_write[k], c_size[k], c_strobe[k], c_wdata[k], m_addr[k], m_wr[k], m_size[k], m_strb[k], m_wdat[k]); else n_pass++;
            end
            n_total++; if (c_len[k] !== 4'h0) $display("FAIL rnd_len[%0d] it=%0d: got %0d want 0", k, it, c_len[k]); else n_pass++;
            n_total++; if (i_addr_ok[k] !== exp_iok || i_data_ok[k] !== exp_iok || i_data[k] !== exp_idata) $display("FAIL rnd_ibus[%0d] it=%0d: got %b %b %h want %b %b %h", k, it, i_addr_ok[k], i_data_ok[k], i_data[k], exp_iok, exp_iok, exp_idata); else n_pass++;
            n_total++; if (d_addr_ok[k] !== exp_dok || d_data_ok[k] !== exp_dok || d_data[k] !== (exp_dok ? c_rdata : 64'h0)) $display("FAIL rnd_dbus[%0d] it=%0d: got %b %b %h want %b", k, it, d_addr_ok[k], d_data_ok[k], d_data[k], exp_dok); else n_pass++;
            n_total++; if (err[k] !== m_err[k]) $display("FAIL rnd_err[%0d] it=%0d: got %b want %b", k, it, err[k], m_err[k]); else n_pass++;
            if (!rst_now) model_step(k, done);
         end
         tick();
      end
      reset = 1'b1;
      quiesce();
   endtask

   initial begin
      reset = 1'b1; i_valid = 1'b0; d_valid = 1'b0; c_ready = 1'b0; c_last = 1'b0;
      i_addr = 64'h0; d_addr = 64'h0; d_size = 3'd0; d_strobe = 8'h0; d_wdata = 64'h0;
      c_rdata = 64'h0;
      #1;
      test_reset();
      test_ibus_read();
      test_priority();
      test_rr();
      test_hold();
      test_watchdog();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
